// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
//   Inverse of the RV32I immediate decode path. The block takes a 32-bit
//   two's-complement immediate, an immediate type and a base instruction. It
//   scatters the immediate bits into the encoding positions for that type.
//   It also flags any immediate that the selected format cannot represent.
//   When a value does not fit, the field holds the truncated bits and the beat
//   is still emitted.
//
//   The pipeline has two stages with a valid/ready handshake at each end:
//     S1 registers the input beat.
//     S2 registers the encoded instruction and its error flag.
//   Latency is 2 cycles and throughput is 1 beat per cycle.
//
// Optional feature (macro IMM_ENC_STATS_EN):
//   Defining the macro adds the parameter CNT_W (default 16) and two
//   saturating counters:
//     enc_count_o  counts output handshakes.
//     err_count_o  counts output handshakes that carry out_err_o = 1.
//   Without the macro, the ports, the counters and CNT_W do not exist.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous reset, active-high
//   in_valid_i    input beat valid
//   in_ready_o    encoder can accept a beat (combinational from out_ready_i)
//   base_instr_i  instruction; bits outside the immediate field pass through
//   imm_i         immediate value
//   imm_src_i     000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt, 111 unsigned-B
//                 (110 is reserved and always flags an error)
//   out_valid_o   encoded beat valid
//   out_ready_i   downstream accepts the beat
//   out_instr_o   encoded instruction
//   out_err_o     immediate not representable in the selected format
//   enc_count_o   (IMM_ENC_STATS_EN) output handshake count
//   err_count_o   (IMM_ENC_STATS_EN) erroneous output handshake count
// -----------------------------------------------------------------------------
module imm_encoder
`ifdef IMM_ENC_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] base_instr_i,
  input  logic [31:0] imm_i,
  input  logic [2:0]  imm_src_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_err_o
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] enc_count_o,
  output logic [CNT_W-1:0] err_count_o
`endif
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_U     = 3'b011;
  localparam logic [2:0] SRC_J     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_UB    = 3'b111;

  // Stage registers.
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_instr_q, s1_instr_d;
  logic [31:0] s1_imm_q,   s1_imm_d;
  logic [2:0]  s1_src_q,   s1_src_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;

  logic        s1_adv, s2_adv;
  logic [31:0] enc_instr;
  logic        enc_err;

  // Sign-extension checks. A field of width n represents imm only when every
  // bit from n-1 upward equals the field's sign bit.
  logic i_range_bad, b_range_bad, j_range_bad;
  assign i_range_bad = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
  assign b_range_bad = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]));
  assign j_range_bad = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]));

  // Scatter the S1 immediate into the base instruction.
  always_comb begin
    enc_instr = s1_instr_q;
    enc_err   = 1'b0;
    case (s1_src_q)
      SRC_I: begin
        enc_instr[31:20] = s1_imm_q[11:0];
        enc_err          = i_range_bad;
      end
      SRC_S: begin
        enc_instr[31:25] = s1_imm_q[11:5];
        enc_instr[11:7]  = s1_imm_q[4:0];
        enc_err          = i_range_bad;
      end
      SRC_B, SRC_UB: begin
        enc_instr[31]    = s1_imm_q[12];
        enc_instr[30:25] = s1_imm_q[10:5];
        enc_instr[11:8]  = s1_imm_q[4:1];
        enc_instr[7]     = s1_imm_q[11];
        // The signed form must sign-extend from bit 12. The unsigned form
        // must have nothing above bit 12.
        if (s1_src_q == SRC_B) enc_err = s1_imm_q[0] | b_range_bad;
        else                   enc_err = s1_imm_q[0] | (|s1_imm_q[31:13]);
      end
      SRC_U: begin
        enc_instr[31:12] = s1_imm_q[31:12];
        enc_err          = |s1_imm_q[11:0];
      end
      SRC_J: begin
        enc_instr[31]    = s1_imm_q[20];
        enc_instr[30:21] = s1_imm_q[10:1];
        enc_instr[20]    = s1_imm_q[11];
        enc_instr[19:12] = s1_imm_q[19:12];
        enc_err          = s1_imm_q[0] | j_range_bad;
      end
      SRC_SHAMT: begin
        // funct7 in [31:25] is left as the base supplied it.
        enc_instr[24:20] = s1_imm_q[4:0];
        enc_err          = |s1_imm_q[31:5];
      end
      default: begin
        // Reserved type: the instruction passes through unchanged.
        enc_err = 1'b1;
      end
    endcase
  end

  // Handshake and next-state logic. A stage advances when it is empty or when
  // the stage after it is advancing.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready_i;
    s1_adv     = !s1_valid_q || s2_adv;

    s1_valid_d = s1_adv ? in_valid_i : s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_imm_d   = s1_imm_q;
    s1_src_d   = s1_src_q;
    if (s1_adv && in_valid_i) begin
      s1_instr_d = base_instr_i;
      s1_imm_d   = imm_i;
      s1_src_d   = imm_src_i;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_adv && s1_valid_q) begin
      s2_instr_d = enc_instr;
      s2_err_d   = enc_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_imm_q   <= s1_imm_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid_q;
  assign out_instr_o = s2_instr_q;
  assign out_err_o   = s2_err_q;

`ifdef IMM_ENC_STATS_EN
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             out_fire;

  // Both counters saturate at all-ones.
  always_comb begin
    out_fire  = s2_valid_q && out_ready_i;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (out_fire && !(&enc_cnt_q))             enc_cnt_d = enc_cnt_q + 1'b1;
    if (out_fire && s2_err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enc_count_o = enc_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
//   This testbench drives imm_encoder through the following stages:
//     1. Reset, then a check of the reset state.
//     2. The directed encoding vectors.
//     3. A backpressure burst.
//     4. A reset in the middle of a stream.
//     5. A randomized stream with random downstream stalls.
//   A reference model compares every output beat against a queue of
//   expected values. The model computes the representable range of each
//   format arithmetically and places the immediate fields with masks and
//   shifts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] base_instr_i;
  logic [31:0] imm_i;
  logic [2:0]  imm_src_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_err_o;
`ifdef IMM_ENC_STATS_EN
  logic [15:0] enc_count_o;
  logic [15:0] err_count_o;
`endif

  imm_encoder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .base_instr_i (base_instr_i),
    .imm_i        (imm_i),
    .imm_src_i    (imm_src_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_instr_o  (out_instr_o),
    .out_err_o    (out_err_o)
`ifdef IMM_ENC_STATS_EN
    ,
    .enc_count_o  (enc_count_o),
    .err_count_o  (err_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          tests  = 0;
  int          failed = 0;
  int          n_out  = 0;
  logic [32:0] expq[$];
  bit          in_fire   = 1'b0;
  bit          held_prev = 1'b0;
  logic [32:0] held_val;
  int          m_enc = 0;
  int          m_err = 0;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model. Bit 32 of the result is the error flag.
  function automatic logic [32:0] ref_enc(input logic [31:0] base, input logic [31:0] imm,
                                          input logic [2:0] src);
    longint      s;
    logic [31:0] ins;
    logic        err;
    s   = longint'($signed(imm));
    ins = base;
    err = 1'b0;
    case (src)
      3'd0: begin
        err = !(s >= -2048 && s <= 2047);
        ins = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
      end
      3'd1: begin
        err = !(s >= -2048 && s <= 2047);
        ins = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd2, 3'd7: begin
        if (src == 3'd2) err = (imm % 2 != 0) || !(s >= -4096 && s <= 4095);
        else             err = (imm % 2 != 0) || (imm >= 32'd8192);
        ins = (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) |
              (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
              (((imm >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        err = (imm % 4096) != 0;
        ins = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
      end
      3'd4: begin
        err = (imm % 2 != 0) || !(s >= -1048576 && s <= 1048575);
        ins = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) |
              (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
              (imm & 32'h000FF000);
      end
      3'd5: begin
        err = imm > 32'd31;
        ins = (base & 32'hFE0FFFFF) | ((imm & 32'h1F) << 20);
      end
      default: begin
        err = 1'b1;
        ins = base;
      end
    endcase
    return {err, ins};
  endfunction

  // One clock cycle. The step samples at the falling edge, scoreboards any
  // output handshake, records any input handshake, and then advances past the
  // rising edge.
  task automatic step();
    logic [32:0] e;
    @(negedge clk_i);
    if (rst_i) begin
      in_fire   = 1'b0;
      held_prev = 1'b0;
    end else begin
      if (held_prev) begin
        chk("hold_valid", {32'b0, out_valid_o}, 33'd1);
        chk("hold_data", {out_err_o, out_instr_o}, held_val);
      end
`ifdef IMM_ENC_STATS_EN
      chk("enc_count", {17'b0, enc_count_o}, 33'(m_enc));
      chk("err_count", {17'b0, err_count_o}, 33'(m_err));
`endif
      if (out_valid_o && out_ready_i) begin
        chk("no_stale", {32'b0, expq.size() != 0}, 33'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("out_instr", {1'b0, out_instr_o}, {1'b0, e[31:0]});
          chk("out_err", {32'b0, out_err_o}, {32'b0, e[32]});
          n_out++;
          m_enc++;
          if (e[32]) m_err++;
          $display("[TB] out #%0d instr=%h err=%b exp_instr=%h exp_err=%b",
                   n_out, out_instr_o, out_err_o, e[31:0], e[32]);
        end
      end
      held_prev = out_valid_o && !out_ready_i;
      held_val  = {out_err_o, out_instr_o};
      in_fire   = in_valid_i && in_ready_o;
      if (in_fire) expq.push_back(ref_enc(base_instr_i, imm_i, imm_src_i));
    end
    @(posedge clk_i);
    #1;
  endtask

  // Offer one beat and hold it until accepted. in_valid_i stays high on
  // return so that beats can run back-to-back.
  task automatic send(input logic [31:0] b, input logic [31:0] im, input logic [2:0] sr);
    int k;
    in_valid_i   = 1'b1;
    base_instr_i = b;
    imm_i        = im;
    imm_src_i    = sr;
    k = 0;
    do begin
      step();
      k++;
    end while (!in_fire && k < 20);
    chk("accept_timeout", {32'b0, in_fire}, 33'd1);
  endtask

  task automatic drain();
    int k;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    k = 0;
    while (expq.size() != 0 && k < 30) begin
      step();
      k++;
    end
    step();
    chk("drain_empty", 33'(expq.size()), 33'd0);
  endtask

  function automatic logic [31:0] gen_imm();
    logic [31:0] edges [20];
    edges = '{32'h0, 32'h1, 32'h2, 32'd31, 32'd32, 32'h7FF, 32'h800, 32'hFFFFF800,
              32'hFFFFF7FF, 32'hFFE, 32'h1000, 32'hFFFFF000, 32'hFFFFEFFF, 32'h1FFE,
              32'h2000, 32'hFFFFE, 32'h100000, 32'hFFF00000, 32'hFFEFFFFE, 32'h12345000};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return edges[$urandom_range(0, 19)];
      2:       return $urandom >> $urandom_range(0, 31);
      default: return 32'($signed(-32'sd1 * $signed(32'($urandom_range(0, 5000)))));
    endcase
  endfunction

  int n_acc, n_before;

  initial begin
    rst_i        = 1'b1;
    in_valid_i   = 1'b0;
    out_ready_i  = 1'b1;
    base_instr_i = '0;
    imm_i        = '0;
    imm_src_i    = '0;
    step();
    step();
    rst_i = 1'b0;
    chk("rst_out_valid", {32'b0, out_valid_o}, 33'd0);
    chk("rst_in_ready", {32'b0, in_ready_o}, 33'd1);
    chk("rst_out_instr", {1'b0, out_instr_o}, 33'd0);
    chk("rst_out_err", {32'b0, out_err_o}, 33'd0);

    // Directed vectors. The expected values are the published encodings,
    // cross-checked through the model.
    chk("vec_I_ok", ref_enc(32'h13, 32'hFFFFF800, 3'b000), {1'b0, 32'h80000013});
    chk("vec_B_ok", ref_enc(32'h63, 32'hFFFFFFFE, 3'b010), {1'b0, 32'hFE000FE3});
    send(32'h00000013, 32'hFFFFF800, 3'b000);
    send(32'h00000013, 32'h00000800, 3'b000);
    send(32'h00000063, 32'hFFFFFFFE, 3'b010);
    send(32'h0000006F, 32'h00000800, 3'b100);
    send(32'h00000037, 32'h12345000, 3'b011);
    send(32'h00000037, 32'h12345001, 3'b011);
    send(32'hFE000033, 32'h0000001F, 3'b101);
    send(32'h00000033, 32'h00000020, 3'b101);
    send(32'hDEADBEEF, 32'h00000004, 3'b110);
    send(32'h00000063, 32'h00001FFE, 3'b111);
    send(32'h00000063, 32'h00002000, 3'b111);
    send(32'h00000023, 32'hFFFFF800, 3'b001);
    drain();

    // Backpressure. With the output stalled, only two of four beats fit.
    out_ready_i = 1'b0;
    n_acc = 0;
    n_before = n_out;
    for (int c = 0; c < 6; c++) begin
      in_valid_i   = (n_acc < 4);
      base_instr_i = 32'h00000013 + 32'(n_acc << 7);
      imm_i        = 32'(n_acc * 3);
      imm_src_i    = 3'b000;
      step();
      if (in_fire) n_acc++;
    end
    chk("bp_accepted", 33'(n_acc), 33'd2);
    chk("bp_in_ready", {32'b0, in_ready_o}, 33'd0);
    drain();
    chk("bp_out_count", 33'(n_out - n_before), 33'd2);

    // Reset with both stages full. The beat offered during reset is ignored.
    out_ready_i = 1'b0;
    send(32'h00000013, 32'd5, 3'b000);
    send(32'h00000013, 32'd6, 3'b000);
    in_valid_i = 1'b1;
    imm_i      = 32'd7;
    rst_i      = 1'b1;
    step();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    expq.delete();
    m_enc = 0;
    m_err = 0;
    chk("midrst_out_valid", {32'b0, out_valid_o}, 33'd0);
    chk("midrst_in_ready", {32'b0, in_ready_o}, 33'd1);
`ifdef IMM_ENC_STATS_EN
    chk("midrst_enc_count", {17'b0, enc_count_o}, 33'd0);
    chk("midrst_err_count", {17'b0, err_count_o}, 33'd0);
`endif
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) step();
    send(32'h00000037, 32'hABCDE000, 3'b011);
    drain();

    // Randomized stream with random stalls.
    in_valid_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid_i || in_fire) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid_i   = 1'b1;
          base_instr_i = $urandom;
          imm_i        = gen_imm();
          imm_src_i    = 3'($urandom_range(0, 7));
        end else begin
          in_valid_i = 1'b0;
        end
      end
      out_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
